// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: ALU control codes,
// opcode/funct constants, datapath mux encodings, FSM state encoding, and
// small decode helpers reused by the ALU decoder.
package mc_control_pkg;

  // ALU control codes, shared with the ALU itself
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control FSM state encoding
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // States that own the shared memory port and may stall on mem_ready
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // ALU code for a supported R-type funct; unsupported functs map to AND
  // but are never executed because DECODE rejects them.
  function automatic logic [3:0] r_alu_ctl(input logic [5:0] fn);
    logic [3:0] ctl;
    case (fn)
      FN_ADD:  ctl = ALU_ADD;
      FN_SUB:  ctl = ALU_SUB;
      FN_AND:  ctl = ALU_AND;
      FN_OR:   ctl = ALU_OR;
      FN_XOR:  ctl = ALU_XOR;
      FN_NOR:  ctl = ALU_NOR;
      FN_SLT:  ctl = ALU_SLT;
      default: ctl = ALU_AND;
    endcase
    return ctl;
  endfunction

  // ALU code for an immediate-form opcode
  function automatic logic [3:0] i_alu_ctl(input logic [5:0] op);
    logic [3:0] ctl;
    case (op)
      OP_ADDI: ctl = ALU_ADD;
      OP_ANDI: ctl = ALU_AND;
      OP_ORI:  ctl = ALU_OR;
      OP_XORI: ctl = ALU_XOR;
      OP_SLTI: ctl = ALU_SLT;
      default: ctl = ALU_AND;
    endcase
    return ctl;
  endfunction

  // True when the opcode/funct pair names an instruction this core runs
  function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT: ok = 1'b1;
          default:                ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_alu_decode.sv
// Combinational ALU-control and legality decode from opcode, funct and the
// current control state. Kept separate so a pipelined control can reuse it.
module alu_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  state_e     state_i,
  output logic [3:0] alu_ctl_o,
  output logic       illegal_o
);

  // Select the ALU operation for the current state and flag bad encodings in DECODE
  always_comb begin
    alu_ctl_o = ALU_AND;
    illegal_o = 1'b0;
    case (state_i)
      S_FETCH, S_DECODE, S_MEM_ADDR: alu_ctl_o = ALU_ADD;
      S_R_EXEC, S_R_WB:              alu_ctl_o = r_alu_ctl(funct_i);
      S_I_EXEC:                      alu_ctl_o = i_alu_ctl(opcode_i);
      S_BRANCH:                      alu_ctl_o = ALU_SUB;
      default:                       alu_ctl_o = ALU_AND;
    endcase
    if ((state_i == S_DECODE) && !insn_legal(opcode_i, funct_i)) begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit. Walks each instruction through fetch,
// decode, execute, memory and writeback, drives the datapath selects and
// write strobes, and bounds every wait on the shared memory port.
// MEM_TIMEOUT must be at least 1.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_z,
  input  logic       mem_ready,
  output logic [3:0] alu_ctl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic       bus_err
);

  // The counter only has to hold MEM_TIMEOUT-1: the wait cycle that would
  // reach MEM_TIMEOUT is the one that aborts.
  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;
  logic             decode_illegal;

  alu_decode u_alu_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .state_i   (state_q),
    .alu_ctl_o (alu_ctl),
    .illegal_o (decode_illegal)
  );

  assign illegal = decode_illegal;

  // A memory state times out on its MEM_TIMEOUT-th stalled cycle; mem_ready wins
  assign timeout = is_mem_state(state_q) && !mem_ready && (wait_cnt_q == CNT_LAST);

  // State register and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Wait counter restarts whenever the FSM moves on or a timeout aborts the access
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (timeout || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (is_mem_state(state_q) && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end
  end

  // Next-state logic and Moore output decode, qualified by mem_ready, alu_z and timeout
  always_comb begin
    state_d    = state_q;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        mem_read  = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          mem_read = 1'b0;
          bus_err  = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (decode_illegal) begin
          state_d = S_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:    state_d = S_R_EXEC;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:        state_d = S_JUMP;
            default:     state_d = S_I_EXEC;
          endcase
        end
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          mem_read = 1'b0;
          bus_err  = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          mem_write = 1'b0;
          bus_err   = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = ((opcode == OP_BEQ) && alu_z) || ((opcode == OP_BNE) && !alu_z);
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle MIPS control unit: the initiator side of the ALU control interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 4-bit ALU control code, datapath mux selects and write strobes; consumes the ALU zero flag to resolve branches.
- Handshakes with a single shared instruction/data memory through mem_ready, with a bounded wait.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent waiting for mem_ready in any memory state before aborting (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- funct  input  6  IR[5:0]
- alu_z  input  1  ALU zero flag (result == 0)
- mem_ready  input  1  memory completes the current access this cycle
- alu_ctl  output  4  ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1101, NOR 1100, SLT 0111
- alu_src_a  output  1  0=PC, 1=reg A
- alu_src_b  output  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  load IR
- pc_write  output  1  load PC
- pc_source  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- reg_write  output  1  register file write
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALUOut, 1=MDR
- illegal  output  1  one-cycle pulse on an unsupported opcode/funct
- bus_err  output  1  one-cycle pulse on a memory timeout

Behaviour:
- States (4-bit): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Reset: rst_n low forces state FETCH and clears the wait counter asynchronously.
- Outputs are a Moore decode of state, plus the mem_ready, alu_z and timeout qualifiers given below. Any output not listed as asserted for a state is 0.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctl=ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_source=00, next DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=ADD (computes the branch target). Dispatch by opcode:
  - 000000 → R_EXEC
  - 100011 (lw) or 101011 (sw) → MEM_ADDR
  - 000100 (beq) or 000101 (bne) → BRANCH
  - 000010 (j) → JUMP
  - 001000 / 001100 / 001101 / 001110 / 001010 (addi/andi/ori/xori/slti) → I_EXEC
  - Any other opcode, or R-type with funct outside {100000, 100010, 100100, 100101, 100110, 100111, 101010}: illegal=1, next FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctl by funct: add→ADD, sub→SUB, and→AND, or→OR, xor→XOR, nor→NOR, slt→SLT. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctl held from R_EXEC. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_ctl: addi→ADD, andi→AND, ori→OR, xori→XOR, slti→SLT. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctl=ADD. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. On mem_ready, next MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready, next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_ctl=SUB, pc_source=01.
  - pc_write = (beq & alu_z) | (bne & ~alu_z), evaluated combinationally in this cycle.
  - Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- Wait counter:
  - Increments each cycle a memory state (FETCH, MEM_RD, MEM_WR) sees mem_ready=0; clears on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: bus_err=1 for one cycle, all strobes low that cycle, next FETCH. No PC or IR update.
  - mem_ready=1 on the timeout cycle wins: the access completes normally and no bus_err is raised.
- Per-instruction latency with zero memory wait: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3 cycles.
- Reset asserted mid-instruction abandons the instruction. No write strobe may be high in the cycle after rst_n deasserts except FETCH's qualified ir_write/pc_write.

Decomposition:
- Shared include file mips_defs.v (with include guard) holds:
  - ALU control code localparams (shared with the ALU)
  - opcode and funct constants
  - alu_src_b and pc_source encodings
  - state encoding
- One combinational sub-module, alu_decode (opcode, funct, state → alu_ctl, illegal), reused by a future pipelined control.

Test Plan:
- Reset held low 3 cycles, mem_ready=1 → state FETCH; after release, cycle 1 asserts ir_write=1, pc_write=1, alu_ctl=0010, alu_src_b=01.
- R-type funct 100111 (nor), mem_ready=1 → alu_ctl=1100 in R_EXEC; reg_write=1, reg_dst=1 in R_WB; FETCH again 4 cycles after the instruction's fetch.
- beq with alu_z=1 → pc_write=1, pc_source=01 in BRANCH. Repeat with bne and alu_z=1 → pc_write=0.
- lw with mem_ready low for 5 cycles in MEM_RD → mem_read/i_or_d held for 6 cycles, then MEM_WB with mem_to_reg=1, reg_write=1.
- MEM_TIMEOUT=4, sw, mem_ready stuck 0 → bus_err pulses on the 4th wait cycle, mem_write drops, next state FETCH; mem_ready=1 on that same cycle instead → no bus_err, normal completion.
- Opcode 111111, then R-type funct 000000 → illegal pulses once in DECODE each time, no reg_write, return to FETCH.
